// File: rtl/led_cube_pkg.sv
// led_cube_pkg: shared states, geometry and bus widths for the LED cube frame scanner.
package led_cube_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;
  localparam int NUM_LAYERS = 8;
  localparam int LATCHES_PER_LAYER = 8;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
endpackage

// File: rtl/led_cube_layer_pwm.sv
// led_cube_layer_pwm: layer display window counter and brightness PWM compare.
module led_cube_layer_pwm #(
  parameter int LAYER_TIME = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [3:0] brightness,
  output logic       layer_on,
  output logic       window_done
);
  localparam int CW = $clog2(LAYER_TIME);
  localparam int STEP = LAYER_TIME / 16;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    window_done = enable && cnt_q == CW'(LAYER_TIME - 1);
    cnt_d = (clear || !enable || window_done) ? '0 : cnt_q + CW'(1);
    layer_on = enable && (32'(cnt_q) / STEP <= 32'(brightness));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/led_cube_single_frame.sv
// led_cube_single_frame: scans an 8x8x8 frame into column latches, then shows each layer with PWM.
module led_cube_single_frame
  import led_cube_pkg::*;
#(
  parameter int LAYER_TIME = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  output logic                         done,
  output logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            data_to_latch,
  input  logic [3:0]                   brightness,
  output logic [NUM_LAYERS-1:0]        Layers,
  output logic [LATCHES_PER_LAYER-1:0] Latches,
  output logic [DATA_W-1:0]            Data
);
  state_t state_q, state_d;
  logic [2:0] layer_q, layer_d, latch_q, latch_d;
  logic [1:0] phase_q, phase_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic done_q, done_d;
  logic layer_on, window_done;
  led_cube_layer_pwm #(.LAYER_TIME(LAYER_TIME)) u_pwm (
    .clk(clk),
    .rst(rst),
    .clear(start),
    .enable(state_q == SHOW),
    .brightness(brightness),
    .layer_on(layer_on),
    .window_done(window_done)
  );
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    latch_d = latch_q;
    phase_d = phase_q;
    data_d = data_q;
    done_d = 1'b0;
    if (stop) begin
      state_d = IDLE;
      layer_d = '0;
      latch_d = '0;
      phase_d = '0;
      data_d = '0;
    end else if (start) begin
      state_d = LOAD;
      layer_d = '0;
      latch_d = '0;
      phase_d = '0;
    end else if (state_q == LOAD) begin
      phase_d = phase_q + 2'd1;
      data_d = phase_q == 2'd1 ? data_to_latch : data_q;
      latch_d = phase_q == 2'd3 ? latch_q + 3'd1 : latch_q;
      state_d = (phase_q == 2'd3 && latch_q == 3'd7) ? SHOW : LOAD;
    end else if (window_done) begin
      state_d = LOAD;
      layer_d = layer_q + 3'd1;
      done_d = layer_q == 3'd7;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      layer_q <= '0;
      latch_q <= '0;
      phase_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      latch_q <= latch_d;
      phase_q <= phase_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  // Outputs decode from state so an async reset blanks them within the same cycle.
  assign addr = state_q != IDLE ? {layer_q, latch_q} : '0;
  assign Latches = (state_q == LOAD && phase_q == 2'd2) ? LATCHES_PER_LAYER'(1) << latch_q : '0;
  assign Layers = layer_on ? NUM_LAYERS'(1) << layer_q : '0;
  assign Data = data_q;
  assign done = done_q;
endmodule

// File: tb/tb_led_cube_single_frame.sv
// tb_led_cube_single_frame: randomized scoreboard bench against a timeline model of the frame scan.
module tb_led_cube_single_frame;
  localparam int LT = 256;
  localparam int WIN = 32 + LT;
  localparam int PER = 8 * WIN;
  typedef struct { int c; int a; int b; int d; } ev_t;
  logic clk = 0, rst = 0, start = 0, stop = 0, done;
  logic [3:0] brightness = 0;
  logic [7:0] data_to_latch, Layers, Latches, Data;
  logic [5:0] addr;
  logic [7:0] mem [64];
  int mode = 0, checks = 0, passed = 0, cyc = 0;
  int active = 0, t = 0, e_prev = 0, e_run = 0, m_prev = 0, m_run = 0, n_done = 0, saved;
  bit start_prev = 0, stop_prev = 0;
  ev_t lat_q[$], done_q[$], run_q[$];

  led_cube_single_frame #(.LAYER_TIME(LT)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .done(done), .addr(addr),
    .data_to_latch(data_to_latch), .brightness(brightness),
    .Layers(Layers), .Latches(Latches), .Data(Data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb data_to_latch = mode == 0 ? 8'hA5 : mode == 1 ? {2'b00, addr} : mem[addr];

  function automatic logic [7:0] exp_data(int a);
    return mode == 0 ? 8'hA5 : mode == 1 ? 8'(a) : mem[a];
  endfunction

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", n, act, exp, cyc);
  endtask

  task automatic check_idle(string n);
    chk(n, int'({Layers, Latches, Data, addr, done}), 0);
  endtask

  // One clock of stimulus; the model derives expected events from time elapsed since start.
  task automatic step(input bit st = 0, input bit sp = 0);
    int off, w, lay, exp_lay;
    @(posedge clk);
    #1;
    if (rst || stop_prev) active = 0;
    else if (start_prev) begin active = 1; t = 0; end
    else if (active != 0) t++;
    start = st; stop = sp; start_prev = st; stop_prev = sp;
    exp_lay = 0;
    if (active != 0) begin
      off = t % PER; lay = off / WIN; w = off % WIN;
      if (t > 0 && off == 0) done_q.push_back('{cyc, 1, 0, 0});
      if (w < 32 && w % 4 == 2) lat_q.push_back('{cyc, 1 << (w / 4), int'(exp_data(lay * 8 + w / 4)), lay * 8 + w / 4});
      if (w >= 32 && (w - 32) / (LT / 16) <= int'(brightness)) exp_lay = 1 << lay;
    end
    if (exp_lay != e_prev) begin
      if (e_prev != 0) run_q.push_back('{cyc, e_prev, e_run, 0});
      e_run = 0;
    end
    e_prev = exp_lay;
    if (exp_lay != 0) e_run++;
  endtask

  task automatic run_to(input int n, input int lay, input int w, input bit rb);
    for (int i = 0; i < n; i++) begin
      if (lay >= 0 && active != 0 && (t % PER) / WIN == lay && (t % PER) % WIN == w) break;
      step();
      if (rb && active != 0 && (t % PER) % WIN == 0) brightness = 4'($urandom_range(0, 15));
    end
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    if (Latches != 0) begin
      if (lat_q.size() == 0) chk("latch_unexpected", int'(Latches), 0);
      else begin
        e = lat_q.pop_front();
        chk("latch_cycle", cyc, e.c);
        chk("latch_onehot", int'(Latches), e.a);
        chk("latch_data", int'(Data), e.b);
        chk("latch_addr", int'(addr), e.d);
      end
    end
    if (done) begin
      n_done++;
      if (done_q.size() == 0) chk("done_unexpected", 1, 0);
      else begin e = done_q.pop_front(); chk("done_cycle", cyc, e.c); end
    end
    if (int'(Layers) != m_prev) begin
      if (m_prev != 0) begin
        if (run_q.size() == 0) chk("layer_run_unexpected", m_prev, 0);
        else begin
          e = run_q.pop_front();
          chk("layer_run_end", cyc, e.c);
          chk("layer_run_value", m_prev, e.a);
          chk("layer_run_len", m_run, e.b);
        end
      end
      m_run = 0;
    end
    m_prev = int'(Layers);
    if (Layers != 0) m_run++;
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    #2 rst = 1;
    repeat (3) step();
    check_idle("reset_outputs");
    rst = 0;
    repeat (5) step();
    check_idle("idle_after_reset");
    brightness = 4'd15;
    step(1, 0);
    run_to(2 * PER + 40, -1, 0, 0);
    chk("two_frame_dones", n_done, 2);
    step(0, 1);
    step();
    check_idle("stop_after_frames");
    mode = 1;
    brightness = 4'd7;
    step(1, 0);
    run_to(PER / 2 + $urandom_range(0, 200), -1, 0, 0);
    step(1, 0);
    run_to(PER + 40, -1, 0, 0);
    step(1, 1);
    step();
    check_idle("stop_wins_over_start");
    mode = 2;
    step(1, 0);
    run_to(PER, 5, 32 + $urandom_range(0, LT - 1), 1);
    step(0, 1);
    step();
    check_idle("stop_in_layer5_show");
    repeat (10) step();
    step(1, 0);
    run_to(PER, 2, 13, 1);
    saved = n_done;
    @(posedge clk);
    #1;
    chk("pre_rst_latch", int'(Latches), 8'h08);
    rst = 1;
    #1;
    check_idle("rst_async_blank");
    active = 0;
    step(1, 0);
    step();
    rst = 0;
    run_to(60, -1, 0, 0);
    check_idle("idle_after_rst_release");
    chk("rst_no_done", n_done, saved);
    chk("latch_queue_drained", lat_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    chk("run_queue_drained", run_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
